cas_recorder: RTL and testbench

- Tape-save path for the Sord M5 core; the counterpart of the CAS tape loader.
- Watches the M5 cassette output line, measures pulse widths on the 10.7 MHz clock enable, decodes UART-framed bytes, and writes them into an on-chip buffer.
- The HPS reads the buffer back through the ioctl upload interface as a CAS image.

---
 rtl/cas_recorder.sv | 161 ++++++++++++++++
 tb/tb_cas_recorder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_recorder.sv
// Sord M5 tape-save path: decodes pulse-width-coded UART frames from the cassette
// output line and stores the bytes in a buffer that the HPS uploads as a CAS image.
module cas_recorder #(
    parameter int AW        = 15,
    parameter int THRESH    = 4000,
    parameter int MIN_TICKS = 200,
    parameter int TIMEOUT   = 100000
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          clk_en_10m7_i,
    input  logic          cas_out_i,
    input  logic          record_en_i,
    input  logic          ioctl_upload_i,
    input  logic          ioctl_rd_i,
    input  logic [AW-1:0] ioctl_addr_i,
    output logic [7:0]    ioctl_din_o,
    output logic [AW:0]   byte_count_o,
    output logic          overflow_o,
    output logic          busy_o
);

    localparam int              IW        = $clog2(TIMEOUT + 1);
    localparam logic [19:0]     THRESH_W  = 20'(THRESH);
    localparam logic [19:0]     MIN_W     = 20'(MIN_TICKS);
    localparam logic [IW-1:0]   TIMEOUT_W = IW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t        state;
    logic          cas_s1, cas_s2, cas_prev;
    logic          rise, fall;
    logic [19:0]   high_cnt;
    logic [IW-1:0] idle_cnt;
    logic          timed_out;
    logic          bit_valid, bit_val;
    logic          record_q, arm_rise;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          accept, full, wr_en;
    logic [7:0]    mem [2**AW];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cas_s1   <= 1'b0;
            cas_s2   <= 1'b0;
            cas_prev <= 1'b0;
            record_q <= 1'b0;
        end else begin
            cas_s1   <= cas_out_i;
            cas_s2   <= cas_s1;
            cas_prev <= cas_s2;
            record_q <= record_en_i;
        end
    end

    assign rise      = cas_s2 & ~cas_prev;
    assign fall      = ~cas_s2 & cas_prev;
    assign arm_rise  = record_en_i & ~record_q;
    assign timed_out = (idle_cnt == TIMEOUT_W);

    // High-phase width is classified on the falling edge; glitches produce no bit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            high_cnt  <= '0;
            idle_cnt  <= '0;
            bit_valid <= 1'b0;
            bit_val   <= 1'b0;
        end else begin
            if (rise)
                high_cnt <= '0;
            else if (clk_en_10m7_i && cas_s2 && high_cnt != '1)
                high_cnt <= high_cnt + 20'd1;

            if (rise || fall)
                idle_cnt <= '0;
            else if (clk_en_10m7_i && !timed_out)
                idle_cnt <= idle_cnt + IW'(1);

            bit_valid <= fall && (high_cnt >= MIN_W);
            if (fall)
                bit_val <= (high_cnt < THRESH_W);
        end
    end

    always_comb begin
        accept = bit_valid && bit_val && (state == STOP) && record_en_i
                 && !arm_rise && !timed_out;
        full   = byte_count_o[AW];
        wr_en  = accept && !full;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shreg        <= '0;
            busy_o       <= 1'b0;
            byte_count_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if (arm_rise) begin
                byte_count_o <= '0;
                overflow_o   <= 1'b0;
            end else if (accept) begin
                if (full)
                    overflow_o <= 1'b1;
                else
                    byte_count_o <= byte_count_o + (AW+1)'(1);
            end

            if (!record_en_i || arm_rise || timed_out) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else if (bit_valid) begin
                case (state)
                    IDLE: begin
                        if (!bit_val) begin
                            state  <= DATA;
                            bitcnt <= '0;
                            busy_o <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg  <= {bit_val, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= STOP;
                    end
                    STOP: begin
                        // A zero stop bit doubles as the start bit of the next frame.
                        if (bit_val) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[byte_count_o[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            ioctl_din_o <= '0;
        else if (ioctl_rd_i && ioctl_upload_i)
            ioctl_din_o <= mem[ioctl_addr_i];
    end

endmodule

// File: tb/tb_cas_recorder.sv
// Bench for cas_recorder: random pulse-width stimulus on a random tick enable,
// checked every settled cycle against a frame-level byte model.
module tb_cas_recorder;

    localparam int AW        = 4;
    localparam int THRESH    = 40;
    localparam int MIN_TICKS = 8;
    localparam int TIMEOUT   = 400;
    localparam int SHORT     = 16;
    localparam int LONG      = 64;
    localparam int GLITCH    = 3;
    localparam int LOWT      = 12;
    localparam int DEPTH     = 2**AW;

    logic          clk, rst_n, ce, cas, rec, upload, rd;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [AW:0]   count;
    logic          ovf, busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   check_en = 0;

    bit         m_in_frame;
    bit         m_frame[$];
    int         m_count;
    bit         m_ovf;
    logic [7:0] m_mem [DEPTH];

    cas_recorder #(.AW(AW), .THRESH(THRESH), .MIN_TICKS(MIN_TICKS), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .clk_en_10m7_i  (ce),
        .cas_out_i      (cas),
        .record_en_i    (rec),
        .ioctl_upload_i (upload),
        .ioctl_rd_i     (rd),
        .ioctl_addr_i   (addr),
        .ioctl_din_o    (din),
        .byte_count_o   (count),
        .overflow_o     (ovf),
        .busy_o         (busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        ce = 0;
        forever begin
            @(posedge clk);
            #1 ce = ($urandom_range(3) != 0);
        end
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("byte_count", 32'(count), 32'(m_count));
                checkOutput("overflow", 32'(ovf), 32'(m_ovf));
                checkOutput("busy", 32'(busy), 32'(m_in_frame));
            end
        end
    end

    function automatic void modelStore(int v);
        if (m_count < DEPTH) begin
            m_mem[m_count] = 8'(v);
            m_count++;
        end else begin
            m_ovf = 1;
        end
    endfunction

    // Frame rules: idle until a 0 start bit, then 8 data bits LSB first and a stop bit.
    function automatic void modelBit(bit b);
        int v;
        if (!rec) return;
        if (!m_in_frame) begin
            if (!b) begin
                m_in_frame = 1;
                m_frame.delete();
            end
        end else begin
            m_frame.push_back(b);
            if (m_frame.size() == 9) begin
                if (b) begin
                    v = 0;
                    for (int i = 0; i < 8; i++) v += int'(m_frame[i]) << i;
                    modelStore(v);
                    m_in_frame = 0;
                end else begin
                    m_frame.delete();
                end
            end
        end
    endfunction

    function automatic void modelReset();
        m_in_frame = 0;
        m_frame.delete();
        m_count = 0;
        m_ovf   = 0;
    endfunction

    task automatic waitTicks(int n);
        int t = 0;
        while (t < n) begin
            @(negedge clk);
            if (ce) t++;
        end
    endtask

    task automatic applyStimulus(int high_ticks);
        cas = 1;
        waitTicks(high_ticks);
        cas = 0;
        check_en = 0;
        repeat (6) @(negedge clk);
        if (high_ticks >= MIN_TICKS) modelBit(high_ticks < THRESH);
        check_en = 1;
        waitTicks(LOWT);
    endtask

    task automatic sendBit(bit b);
        applyStimulus(b ? SHORT : LONG);
    endtask

    task automatic sendByte(logic [7:0] v, bit stop_bit, int glitch_pos);
        sendBit(0);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_pos) applyStimulus(GLITCH);
            sendBit(v[i]);
        end
        sendBit(stop_bit);
    endtask

    task automatic rearm();
        check_en = 0;
        rec = 0;
        repeat (3) @(negedge clk);
        rec = 1;
        repeat (3) @(negedge clk);
        m_in_frame = 0;
        m_frame.delete();
        m_count = 0;
        m_ovf   = 0;
        check_en = 1;
    endtask

    task automatic readCheck(int a, logic [7:0] expected, string name);
        upload = 1;
        rd     = 1;
        addr   = AW'(a);
        @(negedge clk);
        rd = 0;
        checkOutput(name, 32'(din), 32'(expected));
        @(negedge clk);
        checkOutput({name, "_hold"}, 32'(din), 32'(expected));
        upload = 0;
    endtask

    initial begin
        logic [7:0] last_byte;
        rst_n = 0; cas = 0; rec = 0; upload = 0; rd = 0; addr = '0;
        modelReset();
        #12;
        checkOutput("reset_din", 32'(din), 32'h0);
        checkOutput("reset_count", 32'(count), 32'h0);
        checkOutput("reset_ovf", 32'(ovf), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1;
        rearm();

        // Leader then one clean byte.
        repeat (20) applyStimulus(1000 * SHORT / 1000);
        sendBit(0);
        checkOutput("busy_after_start", 32'(busy), 32'h1);
        for (int i = 0; i < 8; i++) sendBit(8'hA5 >> i);
        sendBit(1);
        checkOutput("count_after_a5", 32'(count), 32'd1);
        checkOutput("busy_after_stop", 32'(busy), 32'h0);
        checkOutput("ovf_after_a5", 32'(ovf), 32'h0);
        readCheck(0, 8'hA5, "mem0_a5");

        sendByte(8'h3C, 1, 4);
        readCheck(1, 8'h3C, "mem1_glitch_3c");

        // Five data bits, then silence long enough to trip the idle timeout.
        sendBit(0);
        for (int i = 0; i < 5; i++) sendBit(i[0]);
        check_en = 0;
        waitTicks(TIMEOUT + 100);
        m_in_frame = 0;
        m_frame.delete();
        check_en = 1;
        @(negedge clk);
        checkOutput("busy_after_timeout", 32'(busy), 32'h0);
        checkOutput("count_after_timeout", 32'(count), 32'd2);
        repeat (3) sendBit(1);
        sendByte(8'h12, 1, -1);
        readCheck(2, 8'h12, "mem2_12");

        // Zero stop bit becomes the start bit of the following frame.
        sendByte(8'h99, 0, -1);
        for (int i = 0; i < 8; i++) sendBit(8'h55 >> i);
        sendBit(1);
        checkOutput("count_after_framing", 32'(count), 32'd4);
        readCheck(3, 8'h55, "mem3_55");

        // Disarm mid-frame: partial byte lost, count kept, bits ignored.
        sendBit(0);
        repeat (3) sendBit(1);
        check_en = 0;
        rec = 0;
        repeat (3) @(negedge clk);
        m_in_frame = 0;
        m_frame.delete();
        check_en = 1;
        sendByte(8'h77, 1, -1);
        checkOutput("count_disarmed", 32'(count), 32'd4);
        checkOutput("busy_disarmed", 32'(busy), 32'h0);
        rearm();
        checkOutput("count_rearmed", 32'(count), 32'd0);

        // Fill past capacity.
        last_byte = '0;
        for (int n = 0; n < DEPTH + 1; n++) begin
            last_byte = 8'($urandom);
            if (n == DEPTH - 1) begin
                sendByte(last_byte, 1, -1);
                readCheck(DEPTH - 1, last_byte, "mem_last_slot");
            end else begin
                sendByte(last_byte, 1, -1);
            end
        end
        checkOutput("count_full", 32'(count), 32'd16);
        checkOutput("ovf_full", 32'(ovf), 32'h1);
        rearm();
        checkOutput("count_cleared", 32'(count), 32'd0);
        checkOutput("ovf_cleared", 32'(ovf), 32'h0);

        // Random frames with leaders, glitches and framing errors.
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(3)) sendBit(1);
            sendByte(8'($urandom), $urandom_range(3) != 0,
                     ($urandom_range(2) == 0) ? int'($urandom_range(7)) : -1);
        end
        repeat (2) sendBit(1);
        for (int i = 0; i < m_count; i++) readCheck(i, m_mem[i], "mem_random");

        // Upload path, then reset in the middle of a read.
        rearm();
        sendByte(8'h01, 1, -1);
        sendByte(8'h02, 1, -1);
        sendByte(8'h03, 1, -1);
        readCheck(2, 8'h03, "upload_addr2");
        check_en = 0;
        upload = 1;
        rd     = 1;
        addr   = AW'(1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        checkOutput("reset_mid_read_din", 32'(din), 32'h0);
        checkOutput("reset_mid_read_count", 32'(count), 32'h0);
        checkOutput("reset_mid_read_busy", 32'(busy), 32'h0);
        modelReset();
        @(negedge clk);
        rd = 0;
        upload = 0;
        rst_n = 1;
        check_en = 1;
        repeat (4) @(negedge clk);
        check_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
